// File: rtl/id_scan_pkg.sv
// Shared types and ASCII bounds for the identifier scanner.
package id_scan_pkg;

  typedef enum logic [1:0] {CLS_D, CLS_L, CLS_O} cls_e;
  typedef enum logic [1:0] {R_IDLE, R_LET, R_DIG} rstate_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} cstate_e;

  localparam logic [7:0] ASC_0 = 8'h30;
  localparam logic [7:0] ASC_9 = 8'h39;
  localparam logic [7:0] ASC_A = 8'h61;
  localparam logic [7:0] ASC_Z = 8'h7a;

  function automatic cls_e classify(input logic [7:0] c);
    if (c >= ASC_0 && c <= ASC_9)      return CLS_D;
    else if (c >= ASC_A && c <= ASC_Z) return CLS_L;
    else                               return CLS_O;
  endfunction

endpackage

// File: rtl/id_char_fsm.sv
// Character recognizer: lowercase letter followed by digits; hit pulses on the
// first digit after a letter.
module id_char_fsm
  import id_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       adv,
  input  logic [7:0] ch,
  output rstate_e    state,
  output logic       hit
);

  rstate_e state_q, state_d;
  cls_e    cls;

  assign cls = classify(ch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= R_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = R_IDLE;
    end else if (adv) begin
      case (cls)
        CLS_L:   state_d = R_LET;
        CLS_D:   state_d = (state_q == R_IDLE) ? R_IDLE : R_DIG;
        default: state_d = R_IDLE;
      endcase
    end
  end

  assign hit   = adv & ~clr & (state_q == R_LET) & (cls == CLS_D);
  assign state = state_q;

endmodule

// File: rtl/id_scan_ctrl.sv
// Frame controller around id_char_fsm: counts identifiers per frame.
// Optional ID_SCAN_POS_EN adds first_pos (index of first identifier digit).
module id_scan_ctrl
  import id_scan_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [7:0]       ch,
  input  logic             ch_valid,
  output logic             ch_ready,
  output logic             busy,
  output logic             match_flag,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow,
  output logic             done
`ifdef ID_SCAN_POS_EN
  ,
  output logic [LEN_W-1:0] first_pos
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  cstate_e          st_q, st_d;
  rstate_e          rec_st;
  logic             go, xfer, last, hit;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  assign go   = (st_q == S_IDLE) & start;
  assign xfer = ch_valid & ch_ready;
  assign last = xfer & (idx_q == len_q - LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= S_IDLE;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE:  if (start) st_d = (frame_len != '0) ? S_RUN : S_DONE;
      S_RUN:   if (last)  st_d = S_DONE;
      S_DONE:  st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_comb begin
    ch_ready = (st_q == S_RUN);
    busy     = (st_q != S_IDLE);
    done     = (st_q == S_DONE);
  end

  // Zero-length frames skip RUN, so the recognizer is only reset for real frames.
  id_char_fsm u_fsm (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go & (frame_len != '0)),
    .adv   (xfer),
    .ch    (ch),
    .state (rec_st),
    .hit   (hit)
  );

  assign match_flag = (rec_st == R_DIG);

  always_comb begin
    len_d = len_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (go) begin
      len_d = frame_len;
      idx_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (xfer) idx_d = idx_q + LEN_W'(1);
      if (hit) begin
        if (cnt_q == CNT_MAX) ovf_d = 1'b1;
        else                  cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      len_q <= len_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign match_count = cnt_q;
  assign overflow    = ovf_q;

`ifdef ID_SCAN_POS_EN
  // All-ones means "none yet"; a frame index never reaches it.
  logic [LEN_W-1:0] pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (go)                       pos_d = '1;
    else if (hit && pos_q == '1)  pos_d = idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pos_q <= '1;
    else        pos_q <= pos_d;
  end

  assign first_pos = pos_q;
`endif

endmodule

// File: doc/id_scan_ctrl.md
ID_SCAN_CTRL -- requirements
Module: id_scan_ctrl

Interface
REQ-001 Parameters SHALL be: LEN_W, 8, frame-length and position width; CNT_W, 8, match-counter width.
REQ-002 clk  input  1  single clock; all flops rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  frame start command, sampled in IDLE only.
REQ-005 frame_len  input  LEN_W  characters in frame, latched on accepted start.
REQ-006 ch  input  8  ASCII character.
REQ-007 ch_valid  input  1  ch is valid.
REQ-008 ch_ready  output  1  block accepts ch this cycle; transfer = ch_valid & ch_ready.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 match_flag  output  1  registered; high while the recognizer is inside the digit part of an identifier.
REQ-011 match_count  output  CNT_W  identifiers found in current/last frame.
REQ-012 overflow  output  1  sticky; match_count saturated.
REQ-013 done  output  1  one-cycle pulse at frame end.

Function
REQ-014 Char classes SHALL be: D = "0".."9", L = "a".."z", O = anything else.
REQ-015 Recognizer states SHALL be R_IDLE, R_LET, R_DIG, advancing only on transfer cycles.
REQ-016 R_IDLE: L->R_LET; D,O->R_IDLE.
REQ-017 R_LET: D->R_DIG and increment match_count; L->R_LET; O->R_IDLE.
REQ-018 R_DIG: D->R_DIG; L->R_LET; O->R_IDLE.
REQ-019 match_flag SHALL be 1 in the cycle after a transfer whose next state is R_DIG, else 0 after that transfer; held on non-transfer cycles.
REQ-020 Controller states SHALL be IDLE, RUN, DONE.
REQ-021 IDLE: ch_ready=0; start with frame_len!=0 -> latch length, clear match_count/overflow/index, recognizer to R_IDLE, match_flag 0, go RUN next cycle.
REQ-022 IDLE: start with frame_len==0 -> clear count/overflow, go DONE (done pulses next cycle, count 0).
REQ-023 RUN: ch_ready=1; each transfer increments index; transfer with index==len-1 -> DONE.
REQ-024 DONE: ch_ready=0, done=1 for exactly one cycle, then IDLE.
REQ-025 start in RUN or DONE SHALL be ignored; frame_len changes after latching SHALL have no effect.
REQ-026 match_count SHALL saturate at 2^CNT_W-1; an increment attempted at saturation sets overflow, held until next accepted start.
REQ-027 match_count, overflow, match_flag SHALL hold their final values from DONE until the next accepted start.
REQ-028 Throughput SHALL be one char per cycle with ch_valid held high.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, R_IDLE, ch_ready=0, busy=0, done=0, match_flag=0, match_count=0, overflow=0, index=0; reset mid-frame SHALL abort it with no done pulse.

Configuration
REQ-030 With ID_SCAN_POS_EN defined, output first_pos[LEN_W-1:0] SHALL report the 0-based frame index of the first digit of the first identifier, all-ones if none, reset/cleared to all-ones on start; without it the port and logic SHALL be absent.

Structure
REQ-031 Package id_scan_pkg SHALL hold char-class enum, recognizer-state enum, controller-state enum, ASCII bound constants.
REQ-032 Recognizer (REQ-014..019) SHALL be sub-module id_char_fsm with inputs clk, rst_n, clr, adv, ch and outputs state, hit (count pulse); id_scan_ctrl instantiates it once.

Verification
REQ-033 start, frame_len=7, chars "a1b22 c" back-to-back -> done pulses the cycle after the 7th transfer, match_count=2, match_flag=0, first_pos=1 (if enabled).
REQ-034 frame_len=4, "9a8x", ch_valid toggled every other cycle -> only transfers advance; match_count=1; match_flag high exactly after "8" until "x".
REQ-035 frame_len=0 start -> busy high one cycle, done pulse, match_count=0, ch_ready never high.
REQ-036 CNT_W=2, frame "a1a1a1a1" -> match_count=3, overflow=1; next start clears both.
REQ-037 rst_n low after 3 of 6 chars -> immediate IDLE, outputs zero, no done; new frame "ab12" -> match_count=1.
REQ-038 start pulsed during RUN with new frame_len -> ignored; frame ends at original length.
